// File: rtl/mux8_serializer_if.sv
// mux8_serializer_if: word-in / bit-out handshake bundle for mux8_serializer
//   in_valid/in_ready/in_data       : parallel word channel (upstream -> block)
//   ser_valid/ser_ready/ser_out     : serial bit channel (block -> downstream)
//   ser_last, bit_idx               : last-bit flag and beat counter of the active word
//   modport slave = the serializer, modport master = the agent driving/consuming it
interface mux8_serializer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_out;
  logic       ser_last;
  logic [2:0] bit_idx;
  modport slave (
    input  in_valid, in_data, ser_ready,
    output in_ready, ser_valid, ser_out, ser_last, bit_idx
  );
  modport master (
    output in_valid, in_data, ser_ready,
    input  in_ready, ser_valid, ser_out, ser_last, bit_idx
  );
endinterface

// File: rtl/mux8_serializer.sv
// mux8_serializer: 8-bit parallel-to-serial converter built around an 8:1 bit-select mux
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mux8_serializer_if.slave (word in, bit out, ser_last, bit_idx)
//   MSB_FIRST : 0 sends bit 0 first, 1 sends bit 7 first
module mux_8 (
  input  logic [7:0] data,
  input  logic [2:0] sel,
  output logic       y
);
  assign y = data[sel];
endmodule

module mux8_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input logic                  clk,
  input logic                  rst_n,
  mux8_serializer_if.slave     bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t     state, state_d;
  logic [7:0] hold_q, hold_d, pend_q, pend_d;
  logic [2:0] cnt, cnt_d, sel;
  logic       pend_v, pend_v_d, in_fire, beat, last, mux_y;
  assign bus.in_ready  = rst_n && !pend_v;
  assign bus.ser_valid = state == SHIFT;
  assign bus.ser_last  = bus.ser_valid && last;
  assign bus.bit_idx   = cnt;
  assign bus.ser_out   = mux_y;
  assign in_fire = bus.in_valid && bus.in_ready;
  assign beat    = bus.ser_valid && bus.ser_ready;
  assign last    = cnt == 3'd7;
  assign sel     = MSB_FIRST ? ~cnt : cnt;
  mux_8 u_mux (.data(hold_q), .sel(sel), .y(mux_y));
  always_comb begin
    state_d  = state;
    hold_d   = hold_q;
    cnt_d    = cnt;
    pend_d   = pend_q;
    pend_v_d = pend_v;
    if (state == IDLE) begin
      hold_d  = in_fire ? bus.in_data : hold_q;
      cnt_d   = in_fire ? 3'd0 : cnt;
      state_d = in_fire ? SHIFT : IDLE;
    end else if (beat && !last) begin
      cnt_d = cnt + 3'd1;
    end else if (beat) begin
      // last beat: pending word first, then a same-cycle input word, else drain
      cnt_d    = 3'd0;
      hold_d   = pend_v ? pend_q : in_fire ? bus.in_data : hold_q;
      pend_v_d = 1'b0;
      state_d  = (pend_v || in_fire) ? SHIFT : IDLE;
    end
    // a word arriving while busy parks in the pending slot unless the last beat took it
    if (state == SHIFT && in_fire && !(beat && last)) begin
      pend_d   = bus.in_data;
      pend_v_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      hold_q <= 8'd0;
      cnt    <= 3'd0;
      pend_q <= 8'd0;
      pend_v <= 1'b0;
    end else begin
      state  <= state_d;
      hold_q <= hold_d;
      cnt    <= cnt_d;
      pend_q <= pend_d;
      pend_v <= pend_v_d;
    end
  end
endmodule

// File: tb/tb_mux8_serializer.sv
// tb_mux8_serializer: directed self-checking bench for mux8_serializer (LSB- and MSB-first instances)
module tb_mux8_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  mux8_serializer_if bus0();
  mux8_serializer_if bus1();
  mux8_serializer #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mux8_serializer #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus0.in_valid = 1'b1;
    bus0.in_data = 8'hAA;
    bus1.in_valid = 1'b1;
    bus1.in_data = 8'hAA;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus0.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready c%0d: got %b want 0", c, bus0.in_ready); end
      checks++;
      if (bus0.ser_valid !== 1'b0) begin errors++; $display("FAIL reset_ser_valid c%0d: got %b want 0", c, bus0.ser_valid); end
      checks++;
      if ({bus0.ser_out, bus0.ser_last, bus0.bit_idx} !== 5'd0) begin errors++; $display("FAIL reset_outs c%0d: got %b want 00000", c, {bus0.ser_out, bus0.ser_last, bus0.bit_idx}); end
      checks++;
      if ({bus1.in_ready, bus1.ser_valid, bus1.ser_out} !== 3'd0) begin errors++; $display("FAIL reset_outs_msb c%0d: got %b want 000", c, {bus1.in_ready, bus1.ser_valid, bus1.ser_out}); end
    end
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", bus0.in_ready); end
    tick();
    checks++;
    if ({bus0.in_ready, bus0.ser_valid} !== 2'b10) begin errors++; $display("FAIL idle_after_release: got %b want 10", {bus0.in_ready, bus0.ser_valid}); end
  endtask

  task automatic test_lsb_first;
    logic e[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bus0.ser_ready = 1'b1;
    bus0.in_data = 8'hB4;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus0.ser_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid b%0d: got %b want 1", i, bus0.ser_valid); end
      checks++;
      if (bus0.ser_out !== e[i]) begin errors++; $display("FAIL lsb_bit b%0d: got %b want %b", i, bus0.ser_out, e[i]); end
      checks++;
      if (bus0.bit_idx !== 3'(i)) begin errors++; $display("FAIL lsb_idx b%0d: got %0d want %0d", i, bus0.bit_idx, i); end
      checks++;
      if (bus0.ser_last !== (i == 7)) begin errors++; $display("FAIL lsb_last b%0d: got %b want %b", i, bus0.ser_last, i == 7); end
      tick();
    end
    checks++;
    if (bus0.ser_valid !== 1'b0) begin errors++; $display("FAIL lsb_end_valid: got %b want 0", bus0.ser_valid); end
  endtask

  task automatic test_msb_first;
    logic e[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bus1.ser_ready = 1'b1;
    bus1.in_data = 8'hB4;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus1.ser_valid !== 1'b1) begin errors++; $display("FAIL msb_valid b%0d: got %b want 1", i, bus1.ser_valid); end
      checks++;
      if (bus1.ser_out !== e[i]) begin errors++; $display("FAIL msb_bit b%0d: got %b want %b", i, bus1.ser_out, e[i]); end
      checks++;
      if (bus1.bit_idx !== 3'(i)) begin errors++; $display("FAIL msb_idx b%0d: got %0d want %0d", i, bus1.bit_idx, i); end
      checks++;
      if (bus1.ser_last !== (i == 7)) begin errors++; $display("FAIL msb_last b%0d: got %b want %b", i, bus1.ser_last, i == 7); end
      tick();
    end
    checks++;
    if (bus1.ser_valid !== 1'b0) begin errors++; $display("FAIL msb_end_valid: got %b want 0", bus1.ser_valid); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] wd[3] = '{8'h01, 8'h80, 8'hFF};
    logic [23:0] exp_bits = 24'hFF8001;
    int idx = 0;
    logic fire;
    bus0.ser_ready = 1'b1;
    bus0.in_data = wd[0];
    bus0.in_valid = 1'b1;
    tick();
    idx = 1;
    bus0.in_data = wd[1];
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (bus0.ser_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid k%0d: got %b want 1", k, bus0.ser_valid); end
      checks++;
      if (bus0.ser_out !== exp_bits[k]) begin errors++; $display("FAIL b2b_bit k%0d: got %b want %b", k, bus0.ser_out, exp_bits[k]); end
      checks++;
      if (bus0.bit_idx !== 3'(k % 8)) begin errors++; $display("FAIL b2b_idx k%0d: got %0d want %0d", k, bus0.bit_idx, k % 8); end
      checks++;
      if (bus0.ser_last !== (k % 8 == 7)) begin errors++; $display("FAIL b2b_last k%0d: got %b want %b", k, bus0.ser_last, k % 8 == 7); end
      checks++;
      if (bus0.in_ready !== (k == 0 || k == 8 || k >= 16)) begin errors++; $display("FAIL b2b_in_ready k%0d: got %b want %b", k, bus0.in_ready, k == 0 || k == 8 || k >= 16); end
      fire = bus0.in_valid && bus0.in_ready;
      tick();
      if (fire) begin
        idx++;
        if (idx < 3) bus0.in_data = wd[idx];
        else bus0.in_valid = 1'b0;
      end
    end
    checks++;
    if (bus0.ser_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b want 0", bus0.ser_valid); end
    checks++;
    if (idx !== 3) begin errors++; $display("FAIL b2b_words_taken: got %0d want 3", idx); end
  endtask

  task automatic test_backpressure;
    logic e[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int beats = 0;
    int c = 0;
    bus0.ser_ready = 1'b1;
    bus0.in_data = 8'h5A;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    while (beats < 8 && c < 40) begin
      bus0.ser_ready = pat[c % 4];
      checks++;
      if (bus0.ser_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b want 1", c, bus0.ser_valid); end
      checks++;
      if (bus0.ser_out !== e[beats]) begin errors++; $display("FAIL bp_bit c%0d: got %b want %b", c, bus0.ser_out, e[beats]); end
      checks++;
      if (bus0.bit_idx !== 3'(beats)) begin errors++; $display("FAIL bp_idx c%0d: got %0d want %0d", c, bus0.bit_idx, beats); end
      if (bus0.ser_ready) beats++;
      c++;
      tick();
    end
    bus0.ser_ready = 1'b1;
    checks++;
    if (c !== 16) begin errors++; $display("FAIL bp_cycles: got %0d want 16", c); end
    checks++;
    if (bus0.ser_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid: got %b want 0", bus0.ser_valid); end
  endtask

  task automatic test_reset_mid_word;
    logic e[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bus0.ser_ready = 1'b1;
    bus0.in_data = 8'hC3;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_data = 8'h3C;
    tick();
    bus0.in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus0.ser_valid, bus0.bit_idx, bus0.in_ready} !== 5'b1_011_0) begin errors++; $display("FAIL mid_state: got %b want 10110", {bus0.ser_valid, bus0.bit_idx, bus0.in_ready}); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus0.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready: got %b want 0", bus0.in_ready); end
    tick();
    checks++;
    if ({bus0.ser_valid, bus0.ser_out, bus0.ser_last, bus0.bit_idx} !== 6'd0) begin errors++; $display("FAIL mid_rst_outs: got %b want 000000", {bus0.ser_valid, bus0.ser_out, bus0.ser_last, bus0.bit_idx}); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready: got %b want 1", bus0.in_ready); end
    tick();
    checks++;
    if (bus0.ser_valid !== 1'b0) begin errors++; $display("FAIL mid_pending_dropped: got %b want 0", bus0.ser_valid); end
    bus0.in_data = 8'h0F;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({bus0.ser_valid, bus0.ser_out, bus0.bit_idx} !== {1'b1, e[i], 3'(i)}) begin errors++; $display("FAIL mid_next_word b%0d: got %b want %b", i, {bus0.ser_valid, bus0.ser_out, bus0.bit_idx}, {1'b1, e[i], 3'(i)}); end
      tick();
    end
    checks++;
    if (bus0.ser_valid !== 1'b0) begin errors++; $display("FAIL mid_end_valid: got %b want 0", bus0.ser_valid); end
  endtask

  initial begin
    bus0.in_valid = 1'b0;
    bus0.in_data = 8'h00;
    bus0.ser_ready = 1'b1;
    bus1.in_valid = 1'b0;
    bus1.in_data = 8'h00;
    bus1.ser_ready = 1'b1;
    #2;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux8_serializer.md
# mux8_serializer

Parallel-to-serial converter feeding the 8:1 bit-select mux stage. Accepts 8-bit words on a valid/ready input, holds the active word on the mux `data` inputs, and steps the 3-bit `sel` through the bit positions, emitting one bit per accepted output beat. A one-word pending buffer gives back-to-back streaming with no idle cycles between words. The block instantiates `mux_8` internally for the bit selection.

## Interface
- `MSB_FIRST`, default 0: 0 sends bit 0 first; 1 sends bit 7 first.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: upstream word valid.
- `in_ready` output 1: block can take a word.
- `in_data` input 8: parallel word.
- `ser_valid` output 1: `ser_out` holds a valid bit.
- `ser_ready` input 1: downstream accepts the current bit.
- `ser_out` output 1: serial bit, the `mux_8` output.
- `ser_last` output 1: current bit is the final bit of its word.
- `bit_idx` output 3: beat counter value `cnt`, 0..7.

## Operation
- State: `IDLE`, `SHIFT`. Registers: `hold_q[7:0]` (active word on `mux_8.data`), `cnt[2:0]`, `pend_q[7:0]`, `pend_v`.
- Mux select: `sel = MSB_FIRST ? ~cnt : cnt`.
- Output wiring:
  - `ser_out = hold_q[sel]`, taken through `mux_8`.
  - `ser_valid = (state==SHIFT)`.
  - `ser_last = ser_valid && cnt==7`.
  - `bit_idx = cnt`.
- `in_ready = rst_n && !pend_v`. Input transfer: `in_valid && in_ready`. Output beat: `ser_valid && ser_ready`.
- `IDLE`: an input transfer loads `hold_q`, clears `cnt` to 0 and moves to `SHIFT`.
- `SHIFT`, beat with `cnt<7`: `cnt` increments.
- `SHIFT`, no beat (`ser_ready=0`): `hold_q`, `cnt` and `ser_out` stay stable. Valid is never withdrawn.
- `SHIFT`, last beat (`cnt==7`), in priority order:
  - `pend_v=1`: `hold_q<=pend_q`, `pend_v<=0`, `cnt<=0`, stay in `SHIFT`.
  - else an input transfer in the same cycle: `hold_q<=in_data`, `cnt<=0`, stay in `SHIFT`. The word bypasses the pending buffer.
  - else: go to `IDLE`. `cnt` wraps to 0.
- `SHIFT`, input transfer that is not consumed by a last-beat reload: the word goes to `pend_q` and `pend_v<=1`.
- Last beat, `pend_v=1`, and `in_valid=1`: no transfer, because `in_ready=0` this cycle. `pend_v` clears at the edge, so `in_ready` rises the next cycle.
- Word order is strict FIFO. A word is never dropped or duplicated.

## Timing
- Reset (`rst_n=0` sampled at a rising edge):
  - `state=IDLE`, `cnt=0`, `hold_q=0`, `pend_q=0`, `pend_v=0`.
  - Outputs: `ser_valid=0`, `ser_last=0`, `bit_idx=0`, `ser_out=0`.
  - `in_ready=0` while `rst_n=0`; it is 1 in the first cycle after release.
- Reset mid-word aborts immediately. The active word and the pending word are discarded, with no partial-word completion.
- Latency: input transfer at edge N → `ser_valid=1` with the first bit in the cycle following edge N.
- Throughput with `ser_ready` held at 1: 8 beats per word. Consecutive words run with zero gap cycles when upstream keeps `in_valid=1`.
- `ser_out` is combinational from registers only. There is no combinational path from `ser_ready` or `in_valid` to `ser_out`, `ser_valid` or `in_ready`.
- Capacity: 2 words (active + pending). `in_ready` drops the cycle after the pending buffer fills.

## Test plan
- Reset check: hold `rst_n=0` for 3 cycles with `in_valid=1` → `in_ready=0`, `ser_valid=0`, outputs 0. After release, `in_ready=1`.
- LSB-first, `MSB_FIRST=0`, `ser_ready=1`: send `0xB4` → `ser_out` = 0,0,1,0,1,1,0,1 on 8 consecutive cycles starting 1 cycle after acceptance. `ser_last` only on beat 8, then `ser_valid=0`.
- MSB-first, `MSB_FIRST=1`: send `0xB4` → `ser_out` = 1,0,1,1,0,1,0,0. `bit_idx` still counts 0..7.
- Back-to-back: stream `0x01`, `0x80`, `0xFF` with `in_valid` held high → 24 contiguous valid beats with no gap. `in_ready` is low while the pending buffer is full. Bit order is correct across word boundaries.
- Backpressure: toggle `ser_ready` in the pattern 1,0,0,1,… during `0x5A` → `ser_out` and `bit_idx` hold while `ser_ready=0`. Exactly 8 beats are completed and the word is reproduced.
- Reset mid-word: assert `rst_n=0` after 3 beats of `0xC3` with `0x3C` pending → both words are discarded. The next accepted word `0x0F` serializes from bit 0.
